// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with bubble/hold control and MADD/MSUB state feedback
// Optional EX_MEM_PERF_CNT_EN adds perf_bubble/perf_hold event counters.
module ex_mem_reg #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int OPW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      stall,
  input  logic            flush,
  input  logic [AW-1:0]   ex_wd,
  input  logic            ex_wreg,
  input  logic [DW-1:0]   ex_wdata,
  input  logic            ex_whilo,
  input  logic [DW-1:0]   ex_hi,
  input  logic [DW-1:0]   ex_lo,
  input  logic [OPW-1:0]  ex_aluop,
  input  logic [DW-1:0]   ex_mem_addr,
  input  logic [DW-1:0]   ex_reg2,
  input  logic [2*DW-1:0] hilo_i,
  input  logic [1:0]      cnt_i,
  output logic [AW-1:0]   mem_wd,
  output logic            mem_wreg,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_whilo,
  output logic [DW-1:0]   mem_hi,
  output logic [DW-1:0]   mem_lo,
  output logic [OPW-1:0]  mem_aluop,
  output logic [DW-1:0]   mem_mem_addr,
  output logic [DW-1:0]   mem_reg2,
  output logic [2*DW-1:0] hilo_o,
`ifdef EX_MEM_PERF_CNT_EN
  output logic [31:0]     perf_bubble,
  output logic [31:0]     perf_hold,
`endif
  output logic [1:0]      cnt_o
);

  logic [AW-1:0]   wd_q, wd_d;
  logic            wreg_q, wreg_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            whilo_q, whilo_d;
  logic [DW-1:0]   hi_q, hi_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic [OPW-1:0]  aluop_q, aluop_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   reg2_q, reg2_d;
  logic [2*DW-1:0] hilo_q, hilo_d;
  logic [1:0]      cnt_q, cnt_d;

  logic ex_stall, mem_stall, bubble, hold;
  logic unused_stall;

  assign ex_stall     = stall[2];
  assign mem_stall    = stall[3];
  assign bubble       = !flush && ex_stall && !mem_stall;
  assign hold         = !flush && ex_stall && mem_stall;
  assign unused_stall = ^{stall[5:4], stall[1:0]};

  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    whilo_d = whilo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    aluop_d = aluop_q;
    addr_d  = addr_q;
    reg2_d  = reg2_q;
    hilo_d  = hilo_q;
    cnt_d   = cnt_q;
    if (flush || bubble) begin
      wd_d    = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
      whilo_d = 1'b0;
      hi_d    = '0;
      lo_d    = '0;
      aluop_d = '0;
      addr_d  = '0;
      reg2_d  = '0;
      // A bubble keeps the MADD/MSUB partial result alive for the stalled EX stage
      hilo_d  = flush ? '0 : hilo_i;
      cnt_d   = flush ? 2'b00 : cnt_i;
    end else if (!ex_stall) begin
      wd_d    = ex_wd;
      wreg_d  = ex_wreg;
      wdata_d = ex_wdata;
      whilo_d = ex_whilo;
      hi_d    = ex_hi;
      lo_d    = ex_lo;
      aluop_d = ex_aluop;
      addr_d  = ex_mem_addr;
      reg2_d  = ex_reg2;
      hilo_d  = '0;
      cnt_d   = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      whilo_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      aluop_q <= '0;
      addr_q  <= '0;
      reg2_q  <= '0;
      hilo_q  <= '0;
      cnt_q   <= 2'b00;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      whilo_q <= whilo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      aluop_q <= aluop_d;
      addr_q  <= addr_d;
      reg2_q  <= reg2_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_wd       = wd_q;
  assign mem_wreg     = wreg_q;
  assign mem_wdata    = wdata_q;
  assign mem_whilo    = whilo_q;
  assign mem_hi       = hi_q;
  assign mem_lo       = lo_q;
  assign mem_aluop    = aluop_q;
  assign mem_mem_addr = addr_q;
  assign mem_reg2     = reg2_q;
  assign hilo_o       = hilo_q;
  assign cnt_o        = cnt_q;

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, hold_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      if (bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (hold)   hold_cnt_q   <= hold_cnt_q + 32'd1;
    end
  end

  assign perf_bubble = bubble_cnt_q;
  assign perf_hold   = hold_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - randomized and directed self-checking bench for ex_mem_reg
// Build with EX_MEM_PERF_CNT_EN defined to also check the perf counters.
module tb_ex_mem_reg;

  localparam logic [7:0] EXE_SW_OP = 8'b11101011;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } stage_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  stage_t      in_s;
  stage_t      exp_s;
  logic [31:0] exp_bubble, exp_hold;

  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] perf_bubble, perf_hold;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(in_s.wd), .ex_wreg(in_s.wreg), .ex_wdata(in_s.wdata),
    .ex_whilo(in_s.whilo), .ex_hi(in_s.hi), .ex_lo(in_s.lo),
    .ex_aluop(in_s.aluop), .ex_mem_addr(in_s.addr), .ex_reg2(in_s.reg2),
    .hilo_i(in_s.hilo), .cnt_i(in_s.cnt),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .hilo_o(hilo_o),
`ifdef EX_MEM_PERF_CNT_EN
    .perf_bubble(perf_bubble), .perf_hold(perf_hold),
`endif
    .cnt_o(cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".wd"},    64'(mem_wd),       64'(exp_s.wd));
    check({tag, ".wreg"},  64'(mem_wreg),     64'(exp_s.wreg));
    check({tag, ".wdata"}, 64'(mem_wdata),    64'(exp_s.wdata));
    check({tag, ".whilo"}, 64'(mem_whilo),    64'(exp_s.whilo));
    check({tag, ".hi"},    64'(mem_hi),       64'(exp_s.hi));
    check({tag, ".lo"},    64'(mem_lo),       64'(exp_s.lo));
    check({tag, ".aluop"}, 64'(mem_aluop),    64'(exp_s.aluop));
    check({tag, ".addr"},  64'(mem_mem_addr), 64'(exp_s.addr));
    check({tag, ".reg2"},  64'(mem_reg2),     64'(exp_s.reg2));
    check({tag, ".hilo"},  hilo_o,            exp_s.hilo);
    check({tag, ".cnt"},   64'(cnt_o),        64'(exp_s.cnt));
`ifdef EX_MEM_PERF_CNT_EN
    check({tag, ".pbub"},  64'(perf_bubble),  64'(exp_bubble));
    check({tag, ".phold"}, 64'(perf_hold),    64'(exp_hold));
`endif
  endtask

  // Reference: what MEM should see after the coming edge, from the stage rules
  task automatic model_edge();
    if (rst) begin
      exp_s = '0;
      exp_bubble = 0;
      exp_hold = 0;
    end else if (flush) begin
      exp_s = '0;
    end else if (!stall[2]) begin
      exp_s = in_s;
      exp_s.hilo = '0;
      exp_s.cnt = 2'b00;
    end else if (!stall[3]) begin
      exp_s = '0;
      exp_s.hilo = in_s.hilo;
      exp_s.cnt = in_s.cnt;
      exp_bubble = exp_bubble + 1;
    end else begin
      exp_hold = exp_hold + 1;
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic rand_in();
    in_s.wd    = 5'($urandom);
    in_s.wreg  = 1'($urandom);
    in_s.wdata = $urandom;
    in_s.whilo = 1'($urandom);
    in_s.hi    = $urandom;
    in_s.lo    = $urandom;
    in_s.aluop = 8'($urandom);
    in_s.addr  = $urandom;
    in_s.reg2  = $urandom;
    in_s.hilo  = {$urandom, $urandom};
    in_s.cnt   = 2'($urandom);
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; in_s = '0;
    exp_s = '0; exp_bubble = 0; exp_hold = 0;
    rand_in();
    tick("reset");
    check("reset_wreg", 64'(mem_wreg), 64'd0);

    // Plain pass-through
    rst = 1'b0; in_s = '0;
    in_s.wd = 5'd3; in_s.wreg = 1'b1; in_s.wdata = 32'h0000_1234;
    tick("pass");
    check("pass_wdata", 64'(mem_wdata), 64'h1234);
    check("pass_wd", 64'(mem_wd), 64'd3);

    // Bubble keeps MADD state, then advance
    stall = 6'b000100; in_s.wreg = 1'b1; in_s.whilo = 1'b1;
    in_s.hilo = 64'h1_0000_0002; in_s.cnt = 2'b01;
    tick("bubble");
    check("bubble_hilo", hilo_o, 64'h1_0000_0002);
    check("bubble_wreg", 64'(mem_wreg), 64'd0);
    stall = '0; in_s.hi = 32'h1; in_s.lo = 32'h5;
    tick("madd_done");
    check("madd_lo", 64'(mem_lo), 64'd5);
    check("madd_cnt", 64'(cnt_o), 64'd0);

    // Hold for three cycles with changing EX data
    rst = 1'b1; tick("rst2");
    rst = 1'b0; in_s.wdata = 32'hDEAD_BEEF; tick("load");
    stall = 6'b001100;
    for (int i = 0; i < 3; i++) begin
      in_s.wdata = $urandom;
      tick("hold");
      check("hold_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    end
`ifdef EX_MEM_PERF_CNT_EN
    check("hold_perf", 64'(perf_hold), 64'd3);
`endif

    // Flush beats stall
    stall = 6'b000100; flush = 1'b1; in_s.hilo = 64'hFF;
    tick("flush");
    check("flush_hilo", hilo_o, 64'd0);
    flush = 1'b0;

    // Reset arriving mid-cycle during accumulation
    in_s.cnt = 2'b01; tick("madd_pre");
    #2 rst = 1'b1;
    #1 check_all("rst_async_view");
    tick("rst_mid");
    check("rst_mid_cnt", 64'(cnt_o), 64'd0);
    rst = 1'b0;

    // Store path
    stall = '0; in_s.aluop = EXE_SW_OP;
    in_s.addr = 32'h8000_0010; in_s.reg2 = 32'hCAFE_0001;
    tick("store");
    check("store_aluop", 64'(mem_aluop), 64'(EXE_SW_OP));
    check("store_addr", 64'(mem_mem_addr), 64'h8000_0010);

    // Randomized control mix, including the illegal stall[3]-only pattern
    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      rand_in();
      r = $urandom_range(0, 7);
      stall = 6'($urandom) & 6'b110011;
      if (r >= 4 && r <= 5) stall[3:2] = 2'b01;
      else if (r == 6)      stall[3:2] = 2'b11;
      else if (r == 7)      stall[3:2] = 2'b10;
      flush = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
